// File: rtl/core_pkg.sv
// Core-wide constants shared by the LEGv8 commit-side blocks, plus the state
// encoding of the architectural register file's dump engine.
//
// Contents:
//   XLEN              data width of an architectural register
//   ARCH_REGS         number of architectural registers
//   arf_dump_state_e  dump engine states (idle / running)
package core_pkg;

    localparam int XLEN      = 64;
    localparam int ARCH_REGS = 32;

    typedef enum logic {
        ARF_DUMP_IDLE = 1'b0,
        ARF_DUMP_RUN  = 1'b1
    } arf_dump_state_e;

endpackage

// File: rtl/arf_dump_engine.sv
// Register-dump engine for the architectural register file. It walks the
// register indices 0..ARCH_REGS-1 and offers one beat per index on a
// valid/ready handshake. It finishes with a one-cycle done pulse.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   dump_start   pulse: begin a dump (ignored while one is running)
//   dump_ready   consumer accepts the current beat
//   rd_value     register file value at rd_idx (no bypass, zero reg = 0)
//   rd_idx       register index the engine wants to read
//   dump_valid   beat valid
//   dump_idx     index of the current beat
//   dump_data    value of the current beat
//   dump_busy    dump in progress
//   dump_done    one-cycle pulse after the last beat is accepted
//
// state          | meaning
// ---------------+-----------------------------------------------
// ARF_DUMP_IDLE  | no dump running, index parked at 0
// ARF_DUMP_RUN   | presenting beat dump_idx, waiting for dump_ready
module arf_dump_engine #(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int ARCH_REGS = core_pkg::ARCH_REGS,
    parameter int AW        = $clog2(ARCH_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dump_start,
    input  logic            dump_ready,
    input  logic [XLEN-1:0] rd_value,
    output logic [AW-1:0]   rd_idx,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_busy,
    output logic            dump_done
);
    import core_pkg::*;

    arf_dump_state_e state_q;
    arf_dump_state_e state_d;
    logic [AW-1:0]   idx_q;
    logic            done_q;
    logic            xfer;
    logic            last;

    assign xfer = (state_q == ARF_DUMP_RUN) && dump_ready;
    assign last = (idx_q == AW'(ARCH_REGS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARF_DUMP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARF_DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = ARF_DUMP_RUN;
                end
            end
            ARF_DUMP_RUN: begin
                if (xfer && last) begin
                    state_d = ARF_DUMP_IDLE;
                end
            end
            default: state_d = ARF_DUMP_IDLE;
        endcase
    end

    // Beat index and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (state_q == ARF_DUMP_IDLE) begin
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Outputs: the data follows the live register, so a commit to the
    // stalled index is visible without re-issuing the beat.
    always_comb begin
        dump_valid = (state_q == ARF_DUMP_RUN);
        dump_busy  = (state_q == ARF_DUMP_RUN);
        dump_idx   = idx_q;
        rd_idx     = idx_q;
        dump_data  = rd_value;
        dump_done  = done_q;
    end

endmodule

// File: rtl/arch_regfile_mp.sv
// Multi-port architectural register file for the LEGv8 commit side.
// It has N commit write ports, where the lowest port index wins when
// addresses collide. It has M combinational read ports with an optional
// same-cycle write bypass. It also has a single shadow checkpoint and a
// handshaked register dump engine.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wen/waddr/wdata     per-port commit writes
//   raddr/rdata         combinational read ports
//   ckpt_save           copy post-write register state into the shadow
//   ckpt_restore        copy the shadow into the live registers (drops writes)
//   dump_*              register dump handshake (see arf_dump_engine)
module arch_regfile_mp #(
    parameter int XLEN        = core_pkg::XLEN,
    parameter int ARCH_REGS   = core_pkg::ARCH_REGS,
    parameter int WRITE_PORTS = 4,
    parameter int READ_PORTS  = 4,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 0,
    parameter int AW          = $clog2(ARCH_REGS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [WRITE_PORTS-1:0]              wen,
    input  logic [WRITE_PORTS-1:0][AW-1:0]      waddr,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]    wdata,
    input  logic [READ_PORTS-1:0][AW-1:0]       raddr,
    output logic [READ_PORTS-1:0][XLEN-1:0]     rdata,
    input  logic                                ckpt_save,
    input  logic                                ckpt_restore,
    input  logic                                dump_start,
    output logic                                dump_valid,
    input  logic                                dump_ready,
    output logic [AW-1:0]                       dump_idx,
    output logic [XLEN-1:0]                     dump_data,
    output logic                                dump_busy,
    output logic                                dump_done
);
    import core_pkg::*;

    logic [XLEN-1:0] regs   [ARCH_REGS];
    logic [XLEN-1:0] shadow [ARCH_REGS];
    logic            wr_hit [ARCH_REGS];
    logic [XLEN-1:0] wr_val [ARCH_REGS];

    logic [AW-1:0]   dump_rd_idx;
    logic [XLEN-1:0] dump_rd_value;

    // Per-register winner selection. Ports are scanned from the highest
    // index down, so the lowest enabled port targeting r is assigned last.
    // The zero register never reports a hit, so both the write and the
    // bypass are dropped for it.
    for (genvar r = 0; r < ARCH_REGS; r++) begin : g_win
        always_comb begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
                if (wen[p] && (waddr[p] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata[p];
                end
            end
            if (r == ZERO_REG) begin
                wr_hit[r] = 1'b0;
            end
        end

        // A restore takes priority over commits. The shadow captures the
        // post-write value, and it is left alone when a restore happens in
        // the same cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                regs[r]   <= '0;
                shadow[r] <= '0;
            end else begin
                if (ckpt_restore) begin
                    regs[r] <= shadow[r];
                end else if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
                if (ckpt_save && !ckpt_restore) begin
                    shadow[r] <= wr_hit[r] ? wr_val[r] : regs[r];
                end
            end
        end
    end

    // Read ports. The bypass is suppressed during a restore because the
    // writes of that cycle never land.
    for (genvar q = 0; q < READ_PORTS; q++) begin : g_rd
        assign rdata[q] = (raddr[q] == AW'(ZERO_REG)) ? '0 :
                          ((BYPASS != 0) && !ckpt_restore && wr_hit[raddr[q]]) ?
                          wr_val[raddr[q]] : regs[raddr[q]];
    end

    assign dump_rd_value = (dump_rd_idx == AW'(ZERO_REG)) ? '0 : regs[dump_rd_idx];

    arf_dump_engine #(
        .XLEN      (XLEN),
        .ARCH_REGS (ARCH_REGS),
        .AW        (AW)
    ) u_dump (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_value   (dump_rd_value),
        .rd_idx     (dump_rd_idx),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_arch_regfile_mp.sv
module tb_arch_regfile_mp;
    localparam int XLEN = 64;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int WP   = 4;
    localparam int RP   = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [WP-1:0]              wen;
    logic [WP-1:0][AW-1:0]      waddr;
    logic [WP-1:0][XLEN-1:0]    wdata;
    logic [RP-1:0][AW-1:0]      raddr;
    logic [RP-1:0][XLEN-1:0]    rdata;
    logic [RP-1:0][XLEN-1:0]    rdata_nb;
    logic                       ckpt_save;
    logic                       ckpt_restore;
    logic                       dump_start;
    logic                       dump_ready;
    logic                       dump_valid, dump_valid_nb;
    logic [AW-1:0]              dump_idx, dump_idx_nb;
    logic [XLEN-1:0]            dump_data, dump_data_nb;
    logic                       dump_busy, dump_busy_nb;
    logic                       dump_done, dump_done_nb;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    arch_regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .ckpt_save(ckpt_save),
        .ckpt_restore(ckpt_restore), .dump_start(dump_start),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
    );

    arch_regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .ckpt_save(ckpt_save),
        .ckpt_restore(ckpt_restore), .dump_start(dump_start),
        .dump_valid(dump_valid_nb), .dump_ready(dump_ready),
        .dump_idx(dump_idx_nb), .dump_data(dump_data_nb),
        .dump_busy(dump_busy_nb), .dump_done(dump_done_nb)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_w();
        wen   = '0;
        waddr = '0;
        wdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        clr_w();
        raddr = '0;
        ckpt_save = 1'b0;
        ckpt_restore = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        raddr[0] = 5'd5; raddr[1] = 5'd7; raddr[2] = 5'd31; raddr[3] = 5'd0;
        #1;
        chk("rst_rd0", rdata[0], 0);
        chk("rst_rd2", rdata[2], 0);
        chk("rst_valid", {63'd0, dump_valid}, 0);
        chk("rst_busy", {63'd0, dump_busy}, 0);
        chk("rst_done", {63'd0, dump_done}, 0);
        chk("rst_idx", {59'd0, dump_idx}, 0);

        // port1 x5=AA, port3 x7=BB
        wen = 4'b1010;
        waddr[1] = 5'd5; wdata[1] = 64'hAA;
        waddr[3] = 5'd7; wdata[3] = 64'hBB;
        step();
        clr_w();
        #1;
        chk("wr_x5", rdata[0], 64'hAA);
        chk("wr_x7", rdata[1], 64'hBB);

        // zero register write dropped, no bypass
        wen = 4'b0001; waddr[0] = 5'd0; wdata[0] = 64'h55;
        raddr[0] = 5'd0;
        #1;
        chk("zero_byp", rdata[0], 0);
        step();
        clr_w();
        #1;
        chk("zero_reg", rdata[0], 0);

        // ports 0,2,3 collide on x9
        wen = 4'b1101;
        waddr[0] = 5'd9; wdata[0] = 64'h11;
        waddr[2] = 5'd9; wdata[2] = 64'h22;
        waddr[3] = 5'd9; wdata[3] = 64'h33;
        raddr[0] = 5'd9;
        #1;
        chk("coll_byp", rdata[0], 64'h11);
        chk("coll_nobyp", rdata_nb[0], 0);
        step();
        clr_w();
        #1;
        chk("coll_reg", rdata[0], 64'h11);
        chk("coll_reg_nb", rdata_nb[0], 64'h11);

        // checkpoint save / restore
        wen = 4'b0001; waddr[0] = 5'd3; wdata[0] = 64'h10;
        step();
        clr_w();
        ckpt_save = 1'b1;
        step();
        ckpt_save = 1'b0;
        wen = 4'b0001; waddr[0] = 5'd3; wdata[0] = 64'h20;
        step();
        clr_w();
        raddr[0] = 5'd3; raddr[1] = 5'd4;
        #1;
        chk("pre_rest_x3", rdata[0], 64'h20);
        ckpt_restore = 1'b1;
        wen = 4'b0010; waddr[1] = 5'd4; wdata[1] = 64'h44;
        #1;
        chk("rest_nobyp_x4", rdata[1], 0);
        chk("rest_pre_x3", rdata[0], 64'h20);
        step();
        ckpt_restore = 1'b0;
        clr_w();
        #1;
        chk("rest_x3", rdata[0], 64'h10);
        chk("rest_x4", rdata[1], 0);

        // save + restore together: restore wins, shadow untouched
        wen = 4'b0001; waddr[0] = 5'd3; wdata[0] = 64'h30;
        step();
        clr_w();
        ckpt_save = 1'b1; ckpt_restore = 1'b1;
        step();
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        #1;
        chk("sr_x3", rdata[0], 64'h10);
        wen = 4'b0001; waddr[0] = 5'd3; wdata[0] = 64'h40;
        step();
        clr_w();
        ckpt_restore = 1'b1;
        step();
        ckpt_restore = 1'b0;
        #1;
        chk("sr_shadow_x3", rdata[0], 64'h10);

        // save captures the same-cycle write
        wen = 4'b0001; waddr[0] = 5'd6; wdata[0] = 64'h66;
        ckpt_save = 1'b1;
        step();
        ckpt_save = 1'b0;
        wen = 4'b0001; waddr[0] = 5'd6; wdata[0] = 64'h77;
        step();
        clr_w();
        ckpt_restore = 1'b1;
        step();
        ckpt_restore = 1'b0;
        raddr[0] = 5'd6;
        #1;
        chk("save_wr_x6", rdata[0], 64'h66);

        // fill regs[i] = i+1
        for (int c = 0; c < 8; c++) begin
            wen = 4'b1111;
            for (int p = 0; p < 4; p++) begin
                waddr[p] = AW'(c * 4 + p);
                wdata[p] = 64'(c * 4 + p + 1);
            end
            step();
        end
        clr_w();

        // full dump with ready held high, stray dump_start mid-dump
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("d_busy", {63'd0, dump_busy}, 1);
        for (int b = 0; b < NR; b++) begin
            chk("d_valid", {63'd0, dump_valid}, 1);
            chk("d_idx", {59'd0, dump_idx}, 64'(b));
            chk("d_data", dump_data, (b == 0) ? 64'd0 : 64'(b + 1));
            chk("d_nodone", {63'd0, dump_done}, 0);
            dump_start = (b == 10);
            step();
        end
        dump_start = 1'b0;
        chk("d_done", {63'd0, dump_done}, 1);
        chk("d_end_valid", {63'd0, dump_valid}, 0);
        chk("d_end_busy", {63'd0, dump_busy}, 0);
        chk("d_end_idx", {59'd0, dump_idx}, 0);
        step();
        chk("d_done_pulse", {63'd0, dump_done}, 0);

        // stalled dump, then reset mid-dump
        dump_ready = 1'b0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("s_idx0", {59'd0, dump_idx}, 0);
        step();
        chk("s_hold_idx0", {59'd0, dump_idx}, 0);
        chk("s_hold_valid", {63'd0, dump_valid}, 1);
        dump_ready = 1'b1;
        step();
        dump_ready = 1'b0;
        chk("s_idx1", {59'd0, dump_idx}, 1);
        chk("s_data1", dump_data, 64'd2);
        step();
        chk("s_hold_idx1", {59'd0, dump_idx}, 1);
        chk("s_hold_data1", dump_data, 64'd2);
        wen = 4'b0001; waddr[0] = 5'd1; wdata[0] = 64'h99;
        step();
        clr_w();
        chk("s_live_data1", dump_data, 64'h99);
        dump_ready = 1'b1;
        for (int b = 1; b <= 5; b++) step();
        chk("s_idx6", {59'd0, dump_idx}, 6);
        dump_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r_valid", {63'd0, dump_valid}, 0);
        chk("r_busy", {63'd0, dump_busy}, 0);
        chk("r_done", {63'd0, dump_done}, 0);
        chk("r_idx", {59'd0, dump_idx}, 0);
        raddr[0] = 5'd5; raddr[1] = 5'd7; raddr[2] = 5'd9; raddr[3] = 5'd31;
        #1;
        chk("r_x5", rdata[0], 0);
        chk("r_x7", rdata[1], 0);
        chk("r_x9", rdata[2], 0);
        chk("r_x31", rdata[3], 0);
        step();
        chk("r_nodone", {63'd0, dump_done}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
